// File: rtl/pic_pkg.sv
// Shared constants and types for the PIC16F54 ICSP program-memory loader.
package pic_pkg;

    // Six-bit ICSP command codes (LSB first on the wire)
    localparam logic [5:0] CMD_LOAD  = 6'h02;
    localparam logic [5:0] CMD_READ  = 6'h04;
    localparam logic [5:0] CMD_INC   = 6'h06;
    localparam logic [5:0] CMD_BEGIN = 6'h08;
    localparam logic [5:0] CMD_END   = 6'h0E;
    localparam logic [5:0] CMD_ERASE = 6'h09;

    localparam int CMD_BITS = 6;

    // Address pointer value on programming-mode entry; first Increment lands on 0
    localparam logic [8:0]  ADDR_RESET  = 9'h1FF;
    // Value written to every word by Bulk Erase, also the data latch reset value
    localparam logic [11:0] ERASE_VALUE = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_DATA_IN   = 3'd2,
        ST_RD_FETCH  = 3'd3,
        ST_DATA_OUT  = 3'd4,
        ST_PROG_WAIT = 3'd5,
        ST_ERASE     = 3'd6
    } loader_state_t;

endpackage

// File: rtl/icsp_sync.sv
// Two-flop synchronizer for an asynchronous host pin, with a rising-edge
// pulse derived from the synchronized level.
module icsp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability stage, settled stage, and one-cycle history for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pic_icsp_loader.sv
// ICSP serial loader: owns the program-memory write port while programming
// mode is requested, holds the core in reset, and executes Load / Read /
// Increment / Begin / End / Bulk Erase commands from the host.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | not in programming mode, core may run
// ST_CMD       | shifting in a 6-bit command
// ST_DATA_IN   | shifting in a 16-bit frame for the data latch
// ST_RD_FETCH  | two cycles: address settle, then capture memory word
// ST_DATA_OUT  | driving the 16-bit read frame out, one bit per host clock
// ST_PROG_WAIT | one write strobe, then busy for PROG_CYCLES more cycles
// ST_ERASE     | writing ERASE_VALUE to every address, one per cycle
module pic_icsp_loader
    import pic_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 12,
    parameter int PROG_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              icsp_clk,
    input  logic              icsp_dat_in,
    output logic              icsp_dat_out,
    output logic              icsp_dat_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_adrs,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_rst_n,
    output logic              busy
);

    // Frame = start bit, data word, three pad bits
    localparam int FRAME_W = DATA_W + 4;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMR_W   = $clog2(PROG_CYCLES + 1);

    localparam logic [ADDR_W-1:0] ADDR_INIT = ADDR_W'(ADDR_RESET);
    localparam logic [DATA_W-1:0] ERASE_W   = DATA_W'(ERASE_VALUE);

    logic pm_s;
    logic dat_s;
    logic ck_rise;
    logic pm_rise_unused;
    logic dat_rise_unused;
    logic ck_level_unused;

    icsp_sync u_sync_pm (
        .clk    (clk),
        .rst    (rst),
        .d_i    (prog_mode),
        .sync_o (pm_s),
        .rise_o (pm_rise_unused)
    );

    icsp_sync u_sync_ck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (icsp_clk),
        .sync_o (ck_level_unused),
        .rise_o (ck_rise)
    );

    icsp_sync u_sync_dat (
        .clk    (clk),
        .rst    (rst),
        .d_i    (icsp_dat_in),
        .sync_o (dat_s),
        .rise_o (dat_rise_unused)
    );

    loader_state_t      state_q,    state_d;
    logic [FRAME_W-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [DATA_W-1:0]  latch_q,    latch_d;
    logic [TMR_W-1:0]   tmr_q,      tmr_d;
    logic [ADDR_W-1:0]  ecnt_q,     ecnt_d;
    logic               rd_phase_q, rd_phase_d;

    logic [FRAME_W-1:0] shift_in;
    logic [5:0]         cmd_code;

    // Serial input enters at the MSB so an LSB-first word ends up right-aligned
    // in the top bits once complete.
    assign shift_in = {dat_s, shift_q[FRAME_W-1:1]};
    assign cmd_code = shift_in[FRAME_W-1 -: CMD_BITS];

    // Next-state logic: command decode, shifting, timers and erase sweep
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        addr_d     = addr_q;
        latch_d    = latch_q;
        tmr_d      = tmr_q;
        ecnt_d     = ecnt_q;
        rd_phase_d = rd_phase_q;

        if (!pm_s && state_q != ST_IDLE) begin
            // Host left programming mode: abandon whatever was in flight
            state_d    = ST_IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            addr_d     = ADDR_INIT;
            tmr_d      = '0;
            ecnt_d     = '0;
            rd_phase_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pm_s) begin
                        state_d   = ST_CMD;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                    end
                end

                ST_CMD: begin
                    if (ck_rise) begin
                        if (bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            case (cmd_code)
                                CMD_LOAD:  state_d = ST_DATA_IN;
                                CMD_READ: begin
                                    state_d    = ST_RD_FETCH;
                                    rd_phase_d = 1'b0;
                                end
                                CMD_INC:   addr_d = addr_q + 1'b1;
                                CMD_BEGIN: begin
                                    state_d = ST_PROG_WAIT;
                                    tmr_d   = TMR_W'(PROG_CYCLES);
                                end
                                CMD_ERASE: begin
                                    state_d = ST_ERASE;
                                    ecnt_d  = '0;
                                end
                                CMD_END:   ;
                                default:   ;
                            endcase
                        end else begin
                            shift_d   = shift_in;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_DATA_IN: begin
                    if (ck_rise) begin
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            latch_d   = shift_in[DATA_W:1];
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            state_d   = ST_CMD;
                        end else begin
                            shift_d   = shift_in;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_RD_FETCH: begin
                    if (!rd_phase_q) begin
                        rd_phase_d = 1'b1;
                    end else begin
                        shift_d    = {3'b000, mem_rdata, 1'b0};
                        bit_cnt_d  = '0;
                        rd_phase_d = 1'b0;
                        state_d    = ST_DATA_OUT;
                    end
                end

                ST_DATA_OUT: begin
                    // Bit 0 is already on the pin at entry; each host clock
                    // advances to the next bit, the 16th returns to command.
                    if (ck_rise) begin
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            state_d   = ST_CMD;
                        end else begin
                            shift_d   = {1'b0, shift_q[FRAME_W-1:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_PROG_WAIT: begin
                    if (tmr_q == '0) begin
                        state_d = ST_CMD;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end

                ST_ERASE: begin
                    if (ecnt_q == {ADDR_W{1'b1}}) begin
                        ecnt_d  = '0;
                        state_d = ST_CMD;
                    end else begin
                        ecnt_d = ecnt_q + 1'b1;
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            addr_q     <= ADDR_INIT;
            latch_q    <= ERASE_W;
            tmr_q      <= '0;
            ecnt_q     <= '0;
            rd_phase_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            latch_q    <= latch_d;
            tmr_q      <= tmr_d;
            ecnt_q     <= ecnt_d;
            rd_phase_q <= rd_phase_d;
        end
    end

    // Write strobe is gated by the synchronized mode so an abort stops
    // writes a cycle before the FSM itself falls back to idle.
    assign mem_we = pm_s & (((state_q == ST_PROG_WAIT) && (tmr_q == TMR_W'(PROG_CYCLES)))
                            || (state_q == ST_ERASE));

    assign mem_adrs  = (state_q == ST_ERASE) ? ecnt_q : addr_q;
    assign mem_wdata = (state_q == ST_ERASE)     ? ERASE_W :
                       (state_q == ST_PROG_WAIT) ? latch_q : '0;

    assign busy         = (state_q == ST_PROG_WAIT) || (state_q == ST_ERASE);
    assign icsp_dat_oe  = (state_q == ST_DATA_OUT);
    assign icsp_dat_out = (state_q == ST_DATA_OUT) & shift_q[0];
    assign cpu_rst_n    = rst & ~pm_s & (state_q == ST_IDLE);

endmodule

// File: tb/tb_pic_icsp_loader.sv
// Directed bench for pic_icsp_loader: host-side ICSP driver, 512x12 memory
// model with one-cycle read latency, and a write/busy recorder.
module tb_pic_icsp_loader;

    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_mode = 1'b0;
    logic        icsp_clk = 1'b0;
    logic        icsp_dat_in = 1'b0;
    logic        icsp_dat_out;
    logic        icsp_dat_oe;
    logic [11:0] mem_rdata;
    logic [8:0]  mem_adrs;
    logic [11:0] mem_wdata;
    logic        mem_we;
    logic        cpu_rst_n;
    logic        busy;

    logic [11:0] mem [512];
    logic        clr_mem = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int busy_run = 0;
    int busy_len = 0;

    logic [8:0]  wq_adr [$];
    logic [11:0] wq_dat [$];
    int          wq_cyc [$];

    always #5 clk = ~clk;

    pic_icsp_loader #(.ADDR_W(9), .DATA_W(12), .PROG_CYCLES(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_mode    (prog_mode),
        .icsp_clk     (icsp_clk),
        .icsp_dat_in  (icsp_dat_in),
        .icsp_dat_out (icsp_dat_out),
        .icsp_dat_oe  (icsp_dat_oe),
        .mem_rdata    (mem_rdata),
        .mem_adrs     (mem_adrs),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 12'h000;
        end else if (mem_we === 1'b1) begin
            mem[mem_adrs] <= mem_wdata;
        end
        mem_rdata <= mem[mem_adrs];
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq_adr.push_back(mem_adrs);
            wq_dat.push_back(mem_wdata);
            wq_cyc.push_back(cyc);
        end
        if (busy === 1'b1) begin
            busy_run <= busy_run + 1;
        end else if (busy_run != 0) begin
            busy_len <= busy_run;
            busy_run <= 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wq_adr.delete();
        wq_dat.delete();
        wq_cyc.delete();
    endtask

    task automatic send_bit(input logic b);
        icsp_dat_in = b;
        repeat (H) @(negedge clk);
        icsp_clk = 1'b1;
        last_rise_cyc = cyc;
        repeat (H) @(negedge clk);
        icsp_clk = 1'b0;
    endtask

    task automatic send_cmd(input logic [5:0] c);
        for (int i = 0; i < 6; i++) send_bit(c[i]);
    endtask

    task automatic send_data(input logic [11:0] d);
        logic [15:0] f;
        f = {3'b000, d, 1'b0};
        for (int i = 0; i < 16; i++) send_bit(f[i]);
    endtask

    task automatic read_frame(output logic [15:0] w, output int oec);
        w = '0;
        oec = 0;
        icsp_dat_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            repeat (H) @(negedge clk);
            w[i] = icsp_dat_out;
            if (icsp_dat_oe === 1'b1) oec++;
            icsp_clk = 1'b1;
            repeat (H) @(negedge clk);
            icsp_clk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b required 0 after %0d cycles", tag, busy, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_first_write(input string tag, input logic [8:0] ea, input logic [11:0] ed);
        logic [8:0]  ga;
        logic [11:0] gd;
        checks++;
        if (wq_adr.size() != 1) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required 1", tag, wq_adr.size());
        end
        ga = (wq_adr.size() > 0) ? wq_adr[0] : 9'hxxx;
        gd = (wq_dat.size() > 0) ? wq_dat[0] : 12'hxxx;
        checks++;
        if (ga !== ea) begin
            errors++;
            $display("FAIL %s_adrs: got %h required %h", tag, ga, ea);
        end
        checks++;
        if (gd !== ed) begin
            errors++;
            $display("FAIL %s_wdata: got %h required %h", tag, gd, ed);
        end
    endtask

    task automatic test_reset();
        logic [26:0] obs;
        rst = 1'b0;
        clr_mem = 1'b1;
        repeat (3) @(negedge clk);
        clr_mem = 1'b0;
        obs = {icsp_dat_out, icsp_dat_oe, mem_adrs, mem_wdata, mem_we, cpu_rst_n, busy};
        checks++;
        if (obs !== {1'b0, 1'b0, 9'h1FF, 12'h000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs,
                     {1'b0, 1'b0, 9'h1FF, 12'h000, 1'b0, 1'b0, 1'b0});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_cpu_rst_n: got %b required 1", cpu_rst_n);
        end
    endtask

    task automatic test_enter();
        int d;
        prog_mode = 1'b1;
        d = 0;
        while (cpu_rst_n === 1'b1 && d < 10) begin
            @(negedge clk);
            d++;
        end
        checks++;
        if (d != 2) begin
            errors++;
            $display("FAIL enter_cpu_rst_latency: got %0d required 2", d);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (mem_adrs !== 9'h1FF) begin
            errors++;
            $display("FAIL enter_adrs: got %h required 1ff", mem_adrs);
        end
    endtask

    task automatic test_load_begin();
        clear_log();
        send_cmd(6'h02);
        send_data(12'hA5C);
        send_cmd(6'h08);
        wait_not_busy(40, "load_begin");
        check_first_write("load_begin", 9'h1FF, 12'hA5C);
        checks++;
        if (wq_cyc.size() > 0 && (wq_cyc[0] - last_rise_cyc) != 3) begin
            errors++;
            $display("FAIL load_begin_latency: got %0d required 3", wq_cyc[0] - last_rise_cyc);
        end
        checks++;
        if (busy_len != 17) begin
            errors++;
            $display("FAIL load_begin_busy_len: got %0d required 17", busy_len);
        end
    endtask

    task automatic test_inc_read();
        logic [15:0] w;
        int oec;
        clear_log();
        send_cmd(6'h06);
        checks++;
        if (mem_adrs !== 9'h000) begin
            errors++;
            $display("FAIL inc_read_inc: got %h required 000", mem_adrs);
        end
        send_cmd(6'h02);
        send_data(12'h123);
        send_cmd(6'h08);
        wait_not_busy(40, "inc_read_prog");
        check_first_write("inc_read_prog", 9'h000, 12'h123);
        send_cmd(6'h04);
        read_frame(w, oec);
        checks++;
        if (w !== 16'h0246) begin
            errors++;
            $display("FAIL read_frame: got %h required 0246", w);
        end
        checks++;
        if (oec != 16) begin
            errors++;
            $display("FAIL read_oe_events: got %0d required 16", oec);
        end
        checks++;
        if (icsp_dat_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_oe_after: got %b required 0", icsp_dat_oe);
        end
    endtask

    task automatic test_inc_wrap();
        logic [8:0] exp;
        prog_mode = 1'b0;
        repeat (6) @(negedge clk);
        prog_mode = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 1; i <= 513; i++) begin
            send_cmd(6'h06);
            exp = 9'(i - 1);
            checks++;
            if (mem_adrs !== exp) begin
                errors++;
                $display("FAIL inc_wrap_%0d: got %h required %h", i, mem_adrs, exp);
            end
        end
    endtask

    task automatic test_erase();
        int bad;
        clear_log();
        send_cmd(6'h09);
        send_cmd(6'h06);
        wait_not_busy(700, "erase");
        checks++;
        if (wq_adr.size() != 512) begin
            errors++;
            $display("FAIL erase_count: got %0d required 512", wq_adr.size());
        end
        bad = 0;
        for (int i = 0; i < wq_adr.size() && i < 512; i++)
            if (wq_adr[i] !== 9'(i) || wq_dat[i] !== 12'hFFF) bad++;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== 12'hFFF) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL erase_words: got %0d bad words required 0", bad);
        end
        checks++;
        if (busy_len != 512) begin
            errors++;
            $display("FAIL erase_busy_len: got %0d required 512", busy_len);
        end
        checks++;
        if (mem_adrs !== 9'h000) begin
            errors++;
            $display("FAIL erase_adrs_kept: got %h required 000", mem_adrs);
        end
        send_cmd(6'h06);
        checks++;
        if (mem_adrs !== 9'h001) begin
            errors++;
            $display("FAIL erase_cmd_after: got %h required 001", mem_adrs);
        end
    endtask

    task automatic test_erase_abort();
        int n;
        int d;
        int sz;
        int bad;
        @(negedge clk);
        clr_mem = 1'b1;
        @(negedge clk);
        clr_mem = 1'b0;
        clear_log();
        send_cmd(6'h09);
        n = 0;
        while (wq_adr.size() < 101 && n < 700) begin
            @(negedge clk);
            #1;
            n++;
        end
        prog_mode = 1'b0;
        d = 0;
        while (cpu_rst_n !== 1'b1 && d < 20) begin
            @(negedge clk);
            d++;
        end
        checks++;
        if (d != 3) begin
            errors++;
            $display("FAIL abort_cpu_rst_release: got %0d required 3", d);
        end
        repeat (4) @(negedge clk);
        sz = wq_adr.size();
        checks++;
        if (sz < 101 || sz > 104) begin
            errors++;
            $display("FAIL abort_write_stop: got %0d writes required 101..104", sz);
        end
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b we=%b required 0 0", busy, mem_we);
        end
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== ((i < sz) ? 12'hFFF : 12'h000)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_mem: got %0d bad words required 0", bad);
        end
        prog_mode = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (mem_adrs !== 9'h1FF) begin
            errors++;
            $display("FAIL abort_reentry_adrs: got %h required 1ff", mem_adrs);
        end
        clear_log();
        send_cmd(6'h02);
        send_data(12'h055);
        send_cmd(6'h08);
        wait_not_busy(40, "abort_reprog");
        check_first_write("abort_reprog", 9'h1FF, 12'h055);
    endtask

    task automatic test_reset_mid();
        logic [26:0] obs;
        send_cmd(6'h06);
        send_cmd(6'h02);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst = 1'b0;
        #1;
        obs = {icsp_dat_out, icsp_dat_oe, mem_adrs, mem_wdata, mem_we, cpu_rst_n, busy};
        checks++;
        if (obs !== {1'b0, 1'b0, 9'h1FF, 12'h000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required %h", obs,
                     {1'b0, 1'b0, 9'h1FF, 12'h000, 1'b0, 1'b0, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        clear_log();
        send_cmd(6'h3F);
        repeat (4) @(negedge clk);
        checks++;
        if (wq_adr.size() != 0 || mem_adrs !== 9'h1FF) begin
            errors++;
            $display("FAIL unknown_cmd: got writes=%0d adrs=%h required 0 1ff",
                     wq_adr.size(), mem_adrs);
        end
        send_cmd(6'h08);
        wait_not_busy(40, "latch_reset");
        check_first_write("latch_reset", 9'h1FF, 12'hFFF);
        send_cmd(6'h06);
        checks++;
        if (mem_adrs !== 9'h000) begin
            errors++;
            $display("FAIL unknown_cmd_framing: got %h required 000", mem_adrs);
        end
    endtask

    initial begin
        test_reset();
        test_enter();
        test_load_begin();
        test_inc_read();
        test_inc_wrap();
        test_erase();
        test_erase_abort();
        test_reset_mid();
        prog_mode = 1'b0;
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
